ddr3_dfi_responder: RTL

//  DFI-side responder: the memory end of the DFI link driven by ddr3_core.

---
 rtl/ddr3_dfi_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_dfi_responder.sv
// DFI-side DDR3 stand-in: decodes commands, tracks banks, stores bursts
// and returns read beats after a fixed pipeline delay.
module ddr3_dfi_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 10,
  parameter int RD_DELAY = 4,
  parameter int QDEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [14:0] dfi_address_i,
  input  logic [2:0]  dfi_bank_i,
  input  logic        dfi_cs_n_i,
  input  logic        dfi_ras_n_i,
  input  logic        dfi_cas_n_i,
  input  logic        dfi_we_n_i,
  input  logic        dfi_cke_i,
  input  logic        dfi_reset_n_i,
  input  logic        dfi_odt_i,
  input  logic [31:0] dfi_wrdata_i,
  input  logic        dfi_wrdata_en_i,
  input  logic [3:0]  dfi_wrdata_mask_i,
  input  logic        dfi_rddata_en_i,
  output logic [31:0] dfi_rddata_o,
  output logic        dfi_rddata_valid_o,
  output logic [1:0]  dfi_rddata_dnv_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);
  localparam int CB = COL_BITS - 3;
  localparam int EW = 3 + ROW_BITS + CB;
  localparam int AW = EW + 2;
  localparam int QW = $clog2(QDEPTH);
  localparam logic [QW:0] QONE = 1;

  logic [7:0]          bank_open;
  logic [ROW_BITS-1:0] bank_row [8];
  logic [EW-1:0]       wrq [QDEPTH];
  logic [EW-1:0]       rdq [QDEPTH];
  logic [QW:0]         wq_wp, wq_rp;
  logic [QW:0]         rq_wp, rq_rp;
  logic [1:0]          wcnt, rcnt;
  logic [31:0]         mem [1<<AW];
  logic [RD_DELAY-1:0] pipe_v;
  logic [31:0]         pipe_d [RD_DELAY];

  logic          cmd_ok;
  logic [2:0]    cmd;
  logic          is_act, is_rd, is_wr;
  logic          is_pre, is_ref;
  logic [2:0]    bank;
  logic          a10, misalign, tgt_open;
  logic [CB-1:0] col_b;
  logic [EW-1:0] entry;

  logic          wq_empty, wq_full;
  logic          rq_empty, rq_full;
  logic          wr_beat, wr_pop;
  logic          wr_try, wr_push;
  logic          rd_beat, rd_pop;
  logic          rd_try, rd_push;
  logic [AW-1:0] w_idx, r_idx;
  logic [31:0]   rd_word;
  logic          err_hit;
  logic [2:0]    err_sel;
  logic          unused;

  assign unused = ^{dfi_odt_i, dfi_address_i};

  assign cmd_ok = !dfi_cs_n_i && dfi_cke_i
                  && dfi_reset_n_i;
  assign cmd    = {dfi_ras_n_i, dfi_cas_n_i,
                   dfi_we_n_i};
  assign is_act = cmd_ok && (cmd == 3'b011);
  assign is_rd  = cmd_ok && (cmd == 3'b101);
  assign is_wr  = cmd_ok && (cmd == 3'b100);
  assign is_pre = cmd_ok && (cmd == 3'b010);
  assign is_ref = cmd_ok && (cmd == 3'b001);

  assign bank     = dfi_bank_i;
  assign a10      = dfi_address_i[10];
  assign misalign = |dfi_address_i[2:0];
  assign col_b    = dfi_address_i[COL_BITS-1:3];
  assign tgt_open = bank_open[bank];
  assign entry    = {bank, bank_row[bank], col_b};

  assign wq_empty = (wq_wp == wq_rp);
  assign wq_full  = (wq_wp[QW] != wq_rp[QW])
    && (wq_wp[QW-1:0] == wq_rp[QW-1:0]);
  assign rq_empty = (rq_wp == rq_rp);
  assign rq_full  = (rq_wp[QW] != rq_rp[QW])
    && (rq_wp[QW-1:0] == rq_rp[QW-1:0]);

  assign wr_beat = dfi_wrdata_en_i && !wq_empty;
  assign wr_pop  = wr_beat && (wcnt == 2'd3);
  assign wr_try  = is_wr && tgt_open;
  assign wr_push = wr_try && (!wq_full || wr_pop);

  assign rd_beat = dfi_rddata_en_i && !rq_empty;
  assign rd_pop  = rd_beat && (rcnt == 2'd3);
  assign rd_try  = is_rd && tgt_open;
  assign rd_push = rd_try && (!rq_full || rd_pop);

  assign w_idx   = {wrq[wq_rp[QW-1:0]], wcnt};
  assign r_idx   = {rdq[rq_rp[QW-1:0]], rcnt};
  assign rd_word = rd_beat ? mem[r_idx] : 32'd0;

  // Pick the lowest-numbered protocol error seen this cycle
  always_comb begin
    err_hit = 1'b1;
    err_sel = 3'd0;
    if ((is_rd || is_wr) && !tgt_open)
      err_sel = 3'd1;
    else if (is_act && tgt_open)
      err_sel = 3'd2;
    else if (dfi_wrdata_en_i && wq_empty)
      err_sel = 3'd3;
    else if (dfi_rddata_en_i && rq_empty)
      err_sel = 3'd4;
    else if ((wr_try && wq_full && !wr_pop)
          || (rd_try && rq_full && !rd_pop))
      err_sel = 3'd5;
    else if (is_ref && |bank_open)
      err_sel = 3'd6;
    else if ((is_rd || is_wr) && misalign)
      err_sel = 3'd7;
    else
      err_hit = 1'b0;
  end

  // Bank open/row state; auto-precharge only on accepted pushes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_open <= '0;
      for (int i = 0; i < 8; i++)
        bank_row[i] <= '0;
    end else if (!dfi_reset_n_i) begin
      bank_open <= '0;
    end else begin
      if (is_act && !tgt_open) begin
        bank_open[bank] <= 1'b1;
        bank_row[bank]  <=
          dfi_address_i[ROW_BITS-1:0];
      end
      if (is_pre) begin
        if (a10) bank_open <= '0;
        else     bank_open[bank] <= 1'b0;
      end
      if ((wr_push || rd_push) && a10)
        bank_open[bank] <= 1'b0;
    end
  end

  // Queue pointers and beat counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wq_wp <= '0;
      wq_rp <= '0;
      rq_wp <= '0;
      rq_rp <= '0;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      if (wr_push) wq_wp <= wq_wp + QONE;
      if (wr_pop)  wq_rp <= wq_rp + QONE;
      if (rd_push) rq_wp <= rq_wp + QONE;
      if (rd_pop)  rq_rp <= rq_rp + QONE;
      if (wr_beat) wcnt <= wcnt + 2'd1;
      if (rd_beat) rcnt <= rcnt + 2'd1;
    end
  end

  // Queue storage needs no reset; pointers define validity
  always_ff @(posedge clk_i) begin
    if (wr_push) wrq[wq_wp[QW-1:0]] <= entry;
    if (rd_push) rdq[rq_wp[QW-1:0]] <= entry;
  end

  // Burst array write with per-lane masking
  always_ff @(posedge clk_i) begin
    if (wr_beat)
      for (int i = 0; i < 4; i++)
        if (!dfi_wrdata_mask_i[i])
          mem[w_idx][8*i +: 8] <=
            dfi_wrdata_i[8*i +: 8];
  end

  // Fixed-latency read return pipeline
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_DELAY; i++)
        pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= dfi_rddata_en_i;
      pipe_d[0] <= rd_word;
      for (int i = 1; i < RD_DELAY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  // Sticky error flag, first code kept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_code_o <= 3'd0;
    end else if (err_hit) begin
      err_o <= 1'b1;
      if (!err_o) err_code_o <= err_sel;
    end
  end

  assign dfi_rddata_o       = pipe_d[RD_DELAY-1];
  assign dfi_rddata_valid_o = pipe_v[RD_DELAY-1];
  assign dfi_rddata_dnv_o   = 2'b00;

endmodule
